alu_cmd_driver: RTL

Sequential command front-end for the combinational 16-bit ALU.
- Accepts one operation request over a valid/ready handshake.
- Drives the ALU operand and control inputs from registers and holds them stable for a programmable settle time.
- Captures result/result_X and returns them over a valid/ready response channel.
- Sits between a bus/test master and the ALU so the multi-cycle paths (mul, div, log, sqrt) are sampled only after settling.

---
 rtl/alu_cmd_driver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_cmd_driver.sv
// Valid/ready command front-end for the combinational 16-bit ALU: registers operands, waits a settle time, returns result.
// Optional macro ALU_CMD_DRIVER_OPCHECK_EN rejects opcodes 1100-1111 with resp_err instead of driving the ALU.
module alu_cmd_driver #(
  parameter int SETTLE_BASIC   = 1,
  parameter int SETTLE_COMPLEX = 4,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_result_x,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic [15:0] resp_result_x,
  output logic [3:0]  resp_op,
`ifdef ALU_CMD_DRIVER_OPCHECK_EN
  output logic        resp_err,
`endif
  output logic        busy
);

  localparam logic [CNT_W-1:0] N_BASIC   = (SETTLE_BASIC   < 1) ? CNT_W'(1) : CNT_W'(SETTLE_BASIC);
  localparam logic [CNT_W-1:0] N_COMPLEX = (SETTLE_COMPLEX < 1) ? CNT_W'(1) : CNT_W'(SETTLE_COMPLEX);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             op_complex;
  logic             op_illegal;

  assign accept     = req_valid && (state == IDLE);
  assign capture    = (state == SETTLE) && (cnt == CNT_W'(1));
  assign op_complex = (req_op[3:2] == 2'b10);

`ifdef ALU_CMD_DRIVER_OPCHECK_EN
  assign op_illegal = (req_op[3:2] == 2'b11);
`else
  assign op_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = op_illegal ? RESP : SETTLE;
      SETTLE:  if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= op_complex ? N_COMPLEX : N_BASIC;
    end else if (state == SETTLE) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ALU inputs move only on a legal accept so the combinational paths see stable operands until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_control   <= '0;
      resp_result   <= '0;
      resp_result_x <= '0;
      resp_op       <= '0;
    end else begin
      if (accept && !op_illegal) begin
        alu_a       <= req_a;
        alu_b       <= req_b;
        alu_control <= req_op;
      end
      if (accept && op_illegal) begin
        resp_result   <= '0;
        resp_result_x <= '0;
        resp_op       <= req_op;
      end
      if (capture) begin
        resp_result   <= alu_result;
        resp_result_x <= alu_result_x;
        resp_op       <= alu_control;
      end
    end
  end

`ifdef ALU_CMD_DRIVER_OPCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if (accept && op_illegal) begin
      resp_err <= 1'b1;
    end else if (capture) begin
      resp_err <= 1'b0;
    end
  end
`endif

endmodule
